udp_tx_param: RTL and testbench

Parametrised UDP transmit encapsulator: accepts UDP header fields (ports, length, checksum) on a header handshake and a payload on AXI-Stream, then emits the 8-byte UDP header followed by the payload on a single AXI-Stream output of configurable width with byte-enables. It sits between the application payload source and the IP transmit encapsulator. It fully honours downstream backpressure and checks the declared UDP length against the actual payload byte count.

---
 rtl/udp_tx_param.sv | 103 ++++++++++
 tb/tb_udp_tx_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_param.sv
// udp_tx_param: prepends the 8-byte UDP header to an AXI-Stream payload (hdr handshake + s_axis in, m_axis + m_len_err out, i_clk/i_reset)
module udp_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter bit CHECKSUM_EN = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  s_udp_hdr_tvalid,
  output logic                  s_udp_hdr_tready,
  input  logic [15:0]           s_udp_src_port,
  input  logic [15:0]           s_udp_dst_port,
  input  logic [15:0]           s_udp_length,
  input  logic [15:0]           s_udp_checksum,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  m_len_err
);
  localparam int HDR_BEATS = 8 / KEEP_WIDTH;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
  state_t r_state, w_next;
  logic [63:0] r_hdr, w_hdr_in;
  logic [15:0] r_len, w_ck;
  logic [3:0] r_cnt;
  logic [16:0] r_bytes, w_pop, w_total;
  logic w_free, w_hdr_acc, w_pay_acc, w_len_bad;
  logic [DATA_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic r_last, r_valid, r_len_err;
  assign w_ck = CHECKSUM_EN ? s_udp_checksum : 16'h0000;
  assign w_hdr_in = {w_ck[7:0], w_ck[15:8], s_udp_length[7:0], s_udp_length[15:8],
                     s_udp_dst_port[7:0], s_udp_dst_port[15:8], s_udp_src_port[7:0], s_udp_src_port[15:8]};
  assign w_free = !r_valid || m_axis_tready;
  assign w_total = r_bytes + w_pop;
  assign w_len_bad = {1'b0, r_len} != w_total + 17'd8;
  assign m_axis_tdata = r_data;
  assign m_axis_tkeep = r_keep;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tlast = r_last;
  assign m_len_err = r_len_err;
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) w_pop = w_pop + 17'(s_axis_tkeep[k]);
  end
  always_comb begin
    s_udp_hdr_tready = r_state == IDLE && w_free;
    s_axis_tready = r_state == PAYLOAD && w_free;
    w_hdr_acc = s_udp_hdr_tready && s_udp_hdr_tvalid;
    w_pay_acc = s_axis_tready && s_axis_tvalid;
    w_next = w_hdr_acc ? (HDR_BEATS == 1 ? PAYLOAD : HDR) :
             (r_state == HDR && w_free && r_cnt == 4'(HDR_BEATS - 1)) ? PAYLOAD :
             (w_pay_acc && s_axis_tlast) ? IDLE : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_hdr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_bytes <= '0;
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_valid <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_len_err <= w_pay_acc && s_axis_tlast && w_len_bad;
      if (w_hdr_acc) begin
        r_hdr <= w_hdr_in;
        r_len <= s_udp_length;
        r_cnt <= 4'd1;
        r_bytes <= '0;
        r_data <= w_hdr_in[DATA_WIDTH-1:0];
        r_keep <= '1;
        r_last <= 1'b0;
        r_valid <= 1'b1;
      end else if (r_state == HDR && w_free) begin
        r_data <= r_hdr[int'(r_cnt) * DATA_WIDTH +: DATA_WIDTH];
        r_keep <= '1;
        r_last <= 1'b0;
        r_valid <= 1'b1;
        r_cnt <= r_cnt + 4'd1;
      end else if (w_pay_acc) begin
        r_data <= s_axis_tdata;
        r_keep <= s_axis_tkeep;
        r_last <= s_axis_tlast;
        r_valid <= 1'b1;
        r_bytes <= w_total;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_udp_tx_param.sv
// tb_udp_tx_param: scoreboard bench running one udp_tx_param per stream width (8/16/32/64)
module tb_udp_tx_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_fail = 0;
  localparam logic [15:0] F_SRC [8] = '{16'h1234, 16'h1111, 16'h3333, 16'h0400, 16'h0007, 16'h0009, 16'h00AA, 16'hCAFE};
  localparam logic [15:0] F_DST [8] = '{16'hABCD, 16'h2222, 16'h4444, 16'h0035, 16'h0008, 16'h000A, 16'h00BB, 16'hF00D};
  localparam logic [15:0] F_LEN [8] = '{16'd12, 16'd13, 16'd20, 16'd108, 16'd11, 16'd9, 16'd48, 16'd14};
  localparam logic [15:0] F_CK  [8] = '{16'h0000, 16'hBEEF, 16'h5555, 16'h1357, 16'h2468, 16'h9999, 16'h0000, 16'h4321};
  localparam int          F_N   [8] = '{4, 5, 16, 100, 3, 1, 40, 6};
  localparam logic [7:0]  F_BASE[8] = '{8'h01, 8'hAA, 8'h10, 8'h00, 8'hC0, 8'hD0, 8'h20, 8'h60};
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int W = 8 << g;
    localparam int KB = W / 8;
    localparam bit CK = (g == 1 || g == 2);
    logic rst = 1'b1;
    logic hdr_valid = 1'b0, hdr_ready;
    logic [15:0] src = '0, dst = '0, len = '0, ck = '0;
    logic [W-1:0] s_data = '0, m_data;
    logic [KB-1:0] s_keep = '0, m_keep;
    logic s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic m_valid, m_last, m_err;
    logic m_ready = 1'b1;
    logic [8:0] exp_q[$];
    logic err_q[$];
    int done_cnt = 0, cyc = 0, t_last = 0, c = 0;
    bit mon_off = 1'b0, prev_stall = 1'b0, exp_first = 1'b1, fin = 1'b0;
    logic [W+KB+1:0] saved = '0;
    logic [W-1:0] ed, md;
    logic [KB-1:0] ek;
    logic el;
    udp_tx_param #(.DATA_WIDTH(W), .KEEP_WIDTH(KB), .CHECKSUM_EN(CK)) dut (
      .i_clk(clk), .i_reset(rst),
      .s_udp_hdr_tvalid(hdr_valid), .s_udp_hdr_tready(hdr_ready),
      .s_udp_src_port(src), .s_udp_dst_port(dst), .s_udp_length(len), .s_udp_checksum(ck),
      .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
      .s_axis_tready(s_ready),
      .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
      .m_axis_tready(m_ready), .m_len_err(m_err)
    );
    always @(posedge clk) begin
      #1;
      m_ready = (done_cnt == 2 || done_cnt == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    task automatic send_hdr(input int f, input bit chk);
      logic [63:0] hb;
      hb = {F_SRC[f], F_DST[f], F_LEN[f], CK ? F_CK[f] : 16'h0000};
      src = F_SRC[f];
      dst = F_DST[f];
      len = F_LEN[f];
      ck = F_CK[f];
      hdr_valid = 1'b1;
      do @(negedge clk); while (!hdr_ready);
      @(posedge clk);
      if (chk) begin
        for (int j = 0; j < 8; j++) exp_q.push_back({1'b0, hb[63-8*j -: 8]});
        for (int i = 0; i < F_N[f]; i++) exp_q.push_back({i == F_N[f] - 1, 8'(F_BASE[f] + 8'(i))});
        err_q.push_back(32'(F_LEN[f]) != 8 + F_N[f]);
      end
      #1 hdr_valid = 1'b0;
    endtask
    task automatic send_pay(input int f, input int stop);
      for (int i = 0; i < F_N[f]; i += KB) begin
        for (int k = 0; k < KB; k++) begin
          s_data[8*k +: 8] = (i + k < F_N[f]) ? 8'(F_BASE[f] + 8'(i + k)) : 8'h5A;
          s_keep[k] = i + k < F_N[f];
        end
        s_last = i + KB >= F_N[f];
        s_valid = 1'b1;
        if (i / KB == stop) return;
        do @(negedge clk); while (!s_ready);
        @(posedge clk);
        #1;
      end
      s_valid = 1'b0;
    endtask
    task automatic run(input int a, input int b);
      fork
        for (int f = a; f <= b; f++) send_hdr(f, 1'b1);
        for (int f = a; f <= b; f++) send_pay(f, -1);
      join
    endtask
    always @(negedge clk) if (!rst && !mon_off) begin
      cyc++;
      if (prev_stall) begin
        n_cmp++;
        if ({m_valid, m_last, m_keep, m_data} !== saved) begin
          n_fail++;
          $display("FAIL w%0d stable: got %h required %h", W, {m_valid, m_last, m_keep, m_data}, saved);
        end
      end
      if (hdr_valid && hdr_ready) begin
        n_cmp++;
        if (m_valid && !(m_last && m_ready)) begin
          n_fail++;
          $display("FAIL w%0d holdoff: header accepted with valid=%b last=%b ready=%b", W, m_valid, m_last, m_ready);
        end
      end
      if (m_valid && exp_first) begin
        exp_first = 1'b0;
        if (done_cnt == 5) begin
          n_cmp++;
          if (cyc != t_last + 1) begin
            n_fail++;
            $display("FAIL w%0d gap: beat0 at cycle %0d required %0d", W, cyc, t_last + 1);
          end
        end
      end
      if (m_valid && m_last && !prev_stall) begin
        n_cmp++;
        if (err_q.size() == 0 || m_err !== err_q[0]) begin
          n_fail++;
          $display("FAIL w%0d len_err: got %b required %b", W, m_err, err_q.size() ? err_q[0] : 1'b0);
        end
      end else if (m_err !== 1'b0) begin
        n_fail++;
        $display("FAIL w%0d len_err stray: got %b required 0", W, m_err);
      end
      if (m_valid && m_ready) begin
        c = 0;
        el = 1'b0;
        ed = '0;
        md = '0;
        ek = '0;
        for (int k = 0; k < KB; k++) if (!el && c < exp_q.size()) begin
          ed[8*k +: 8] = exp_q[c][7:0];
          md[8*k +: 8] = 8'hFF;
          ek[k] = 1'b1;
          el = exp_q[c][8];
          c++;
        end
        n_cmp++;
        if (m_keep !== ek || m_last !== el || (m_data & md) !== ed) begin
          n_fail++;
          $display("FAIL w%0d beat: got keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                   W, m_keep, m_last, m_data & md, ek, el, ed);
        end
        repeat (c) void'(exp_q.pop_front());
        if (m_last) begin
          done_cnt++;
          t_last = cyc;
          exp_first = 1'b1;
          if (err_q.size()) void'(err_q.pop_front());
        end
      end
      prev_stall = m_valid && !m_ready;
      saved = {m_valid, m_last, m_keep, m_data};
    end
    initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m_valid, m_last, m_err, hdr_ready, s_ready} !== 5'b00010 || m_data !== '0 || m_keep !== '0) begin
        n_fail++;
        $display("FAIL w%0d reset: got v/l/e/hr/sr=%b%b%b%b%b data=%h keep=%h required 00010 0 0",
                 W, m_valid, m_last, m_err, hdr_ready, s_ready, m_data, m_keep);
      end
      @(posedge clk);
      #1;
      run(0, 5);
      wait (done_cnt == 6);
      @(posedge clk);
      #1 mon_off = 1'b1;
      send_hdr(6, 1'b0);
      send_pay(6, 3);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m_valid, s_ready, m_err, hdr_ready} !== 4'b0001) begin
        n_fail++;
        $display("FAIL w%0d midreset: got v/sr/e/hr=%b%b%b%b required 0001", W, m_valid, s_ready, m_err, hdr_ready);
      end
      prev_stall = 1'b0;
      exp_first = 1'b1;
      mon_off = 1'b0;
      @(posedge clk);
      #1;
      run(7, 7);
      wait (done_cnt == 7);
      repeat (2) @(posedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL w%0d leftover: got %0d bytes pending required 0", W, exp_q.size());
      end
      fin = 1'b1;
    end
  end
  initial begin
    wait (u[0].fin && u[1].fin && u[2].fin && u[3].fin);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    repeat (20000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
